// File: rtl/ram_burst_ctrl_1024x32_neg.sv
// Burst front-end for a 1024x32 single-port negedge RAM.
// Takes one burst command at a time, streams write beats into the RAM or
// streams read data back through a small return buffer with backpressure.
// Every flop in this block is clocked on the falling edge of clk.
//
// Handshakes: a transfer happens on a falling edge where valid and ready are
// both high. cmd_ready and wr_ready never depend on the matching valid.
// rd_valid means the buffer head is presented on rd_data. rd_data holds
// until the beat is popped by rd_ready.
module ram_burst_ctrl_1024x32_neg #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int RBUF_DEPTH = 4   // power of two; also the read credit limit
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dout
);

  localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam int CW = $clog2(RBUF_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] remaining;

  // Read return pipe: rd_p1 marks a read strobe on the RAM port,
  // rd_p2 marks RAM data that lands in the buffer on the next edge.
  logic rd_p1;
  logic rd_p2;

  // Return buffer
  logic [DW-1:0] buf_mem [RBUF_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   inflight;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign wr_ready  = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign rd_valid  = (count != '0);
  assign rd_data   = buf_mem[rp];

  assign push = rd_p2;
  assign pop  = rd_valid && rd_ready;

  // Reads in flight plus buffered beats must never exceed the buffer size,
  // which is what makes buffer overflow impossible.
  assign inflight = {1'b0, count} + (CW+1)'(rd_p1) + (CW+1)'(rd_p2);
  assign issue    = (state == S_READ) && (inflight < (CW+1)'(RBUF_DEPTH));

  // Control FSM, RAM port registers and read return pipe
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_di    <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      rd_p1  <= issue;
      rd_p2  <= rd_p1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_wr ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            ram_we    <= 1'b1;
            ram_addr  <= cur_addr;
            ram_di    <= wr_data;
            cur_addr  <= cur_addr + AW'(1);
            remaining <= remaining - AW'(1);
            if (remaining == '0) state <= S_IDLE;
          end
        end
        S_READ: begin
          if (issue) begin
            ram_re    <= 1'b1;
            ram_addr  <= cur_addr;
            cur_addr  <= cur_addr + AW'(1);
            remaining <= remaining - AW'(1);
            if (remaining == '0) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Wait for every issued read to be consumed so the next command
          // cannot overtake data still on its way out.
          if (!rd_p1 && !rd_p2 && (count == '0)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return buffer pointers and occupancy
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Return buffer storage; contents are don't-care while count is zero
  always_ff @(negedge clk) begin
    if (push) buf_mem[wp] <= ram_dout;
  end

endmodule

// File: doc/ram_burst_ctrl_1024x32_neg.md
Name: ram_burst_ctrl_1024x32_neg

Overview:
Burst front-end for the 1024x32 single-port negedge RAM (sync write, registered read with read-enable).
- Accepts one burst command at a time over a valid/ready command channel.
- Streams write beats into the RAM, or streams read data back out through a 4-entry output buffer with backpressure.
- Drives the RAM's we/re/addr/di directly and captures its dout.

Parameters:
AW, 10, address width (RAM depth 2^AW)
DW, 32, data width
RBUF_DEPTH, 4, read-return buffer entries (also the read credit limit)

Ports:
clk  in  1  clock; every flop in this block triggers on negedge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready; high only in IDLE and rst low
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  burst start address
cmd_len  in  AW  beats minus one (0..1023)
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat ready; high only in WRITE
wr_data  in  DW  write beat data
rd_valid  out  1  read buffer non-empty
rd_ready  in  1  consumer ready
rd_data  out  DW  read buffer head
busy  out  1  state != IDLE
ram_we  out  1  RAM write enable, registered
ram_re  out  1  RAM read enable, registered
ram_addr  out  AW  RAM address, registered
ram_di  out  DW  RAM write data, registered
ram_dout  in  DW  RAM registered read data

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE.
  - ram_we, ram_re, ram_addr, ram_di = 0.
  - Buffer emptied; rd_valid = 0; busy = 0; outstanding count = 0.
  - cmd_ready = 0 while rst is high.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_valid & cmd_ready at a negedge latches cur_addr = cmd_addr, remaining = cmd_len.
  - Goes to WRITE if cmd_wr = 1, else READ.
- WRITE:
  - wr_ready = 1.
  - Each wr_valid & wr_ready edge registers ram_we = 1, ram_addr = cur_addr, ram_di = wr_data. The RAM writes on the next negedge.
  - Edges with no beat register ram_we = 0. ram_we is never high two edges for one beat.
  - cur_addr increments modulo 2^AW (1023 -> 0).
  - The beat accepted with remaining = 0 returns to IDLE on that edge.
- READ:
  - Issue rule: issue when outstanding + occupancy < RBUF_DEPTH. Issue registers ram_re = 1, ram_addr = cur_addr, then increments cur_addr (mod 2^AW) and decrements remaining. Otherwise ram_re = 0.
  - Outstanding is tracked by a 2-stage valid pipe. A read issued (ram_re high) after edge N is sampled by the RAM at N+1, and ram_dout is pushed into the buffer at N+2.
  - Issuing the beat with remaining = 0 moves to DRAIN.
- DRAIN:
  - No issues.
  - Returns to IDLE when the pipe is empty and the buffer is empty. This preserves ordering with the next command.
- Read buffer:
  - FIFO; pop on rd_valid & rd_ready.
  - Push and pop on the same edge are both allowed.
  - Overflow is impossible by the credit rule.
- Latency:
  - Command accepted edge E0 -> ram_re high after E1 -> RAM reads at E2 -> rd_valid high after E3.
  - With rd_ready held 1, one beat per edge is sustained.
- ram_we and ram_re are never high simultaneously.
- Write-then-read coherence:
  - Last write beat at W -> IDLE at W -> earliest read accept at W+1 -> first ram_re after W+2.
  - The write has completed at W+1, so the read returns the new data.
- Reset mid-burst:
  - Burst is abandoned; no further RAM strobes.
  - Buffered data is discarded.
  - After rst falls, the block is in IDLE with cmd_ready = 1.

Test Plan:
1. Reset: hold rst, then release → all RAM outputs 0, rd_valid = 0, busy = 0, cmd_ready = 1.
2. Write burst: cmd_wr = 1, addr = 0x010, len = 3, data 0xA0..0xA3 with continuous wr_valid → ram_we high exactly 4 edges at addresses 0x010..0x013, then IDLE. Read-back burst returns 0xA0..0xA3 with first rd_valid 3 edges after accept.
3. Wrap: write addr = 0x3FE, len = 3 → writes land at 0x3FE, 0x3FF, 0x000, 0x001. Read-back matches.
4. Backpressure: read len = 15 with rd_ready low for 10 edges → at most 4 reads outstanding+buffered, ram_re then low. No data lost or reordered after rd_ready rises. With rd_ready = 1, one beat per edge.
5. Write gaps: wr_valid toggling 1,0,1,1 → ram_we follows with one-edge lag; no spurious writes.
6. Async reset mid-read (after 5 of 16 beats) → ram_re drops immediately, rd_valid = 0. Next command is accepted normally.
